seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
- Decodes 4-bit hex nibbles to active-low segment patterns, with a per-digit decimal point, per-digit blanking and optional leading-zero suppression.
- Scans one digit at a time, with a dead interval between digits to stop ghosting.
- Sits between the datapath, which presents packed nibbles, and the board display pins.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_lz_mask.sv | 25 ++
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: blank pattern, hex decode table and decoder.
package seg7_pkg;

  // All segments and the decimal point off (active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Hex nibble to active-low segment pattern; also used by the single-digit decoder.
  function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero suppression mask: a digit goes dark when it and every digit
// above it is a zero nibble with no decimal point. Digit 0 always shows.
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    lz_en_i,
  output logic [NUM_DIGITS-1:0]   mask_o
);

  // clear_from[i] = digits i..NUM_DIGITS-1 are all zero with no DP lit.
  logic [NUM_DIGITS:0] clear_from;

  assign clear_from[NUM_DIGITS] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    localparam bit IS_LSD = (gi == 0);
    assign clear_from[gi] = clear_from[gi+1] & (value_i[4*gi +: 4] == 4'h0) & ~dp_i[gi];
    assign mask_o[gi]     = lz_en_i & clear_from[gi] & ~IS_LSD;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with shadow registers,
// a dead interval at the start of every digit slot and registered outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int DEAD_CYCLES   = 500,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_DEAD = DIV_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // Pin level of an inactive anode; XOR with a one-hot select gives the active level.
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    lz_en_q, lz_en_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [3:0]              cur_nib;

  seg7_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .value_i (value_q),
    .dp_i    (dp_q),
    .lz_en_i (lz_en_q),
    .mask_o  (lz_mask)
  );

  // Shadow registers follow the inputs only on a load strobe.
  always_comb begin
    value_d = value_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    lz_en_d = lz_en_q;
    if (load) begin
      value_d = value;
      dp_d    = dp;
      blank_d = blank;
      lz_en_d = lz_en;
    end
  end

  // Slot divider and digit index; disabling parks both at zero.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (!en) begin
      div_d = '0;
      idx_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Output pattern for the current slot: blank beats suppression beats decode.
  always_comb begin
    an_sel        = '0;
    an_sel[idx_q] = 1'b1;
    cur_nib       = value_q[idx_q*4 +: 4];
    seg_d         = SEG_OFF;
    an_d          = AN_OFF;
    if (en) begin
      if (div_q >= DIV_DEAD) begin
        an_d = an_sel ^ AN_OFF;
      end
      if (!blank_q[idx_q] && !lz_mask[idx_q]) begin
        seg_d = {~dp_q[idx_q], seg7_hex(cur_nib)};
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      lz_en_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      value_q <= value_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      lz_en_q <= lz_en_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 dead).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [7:0]  seg;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (8),
    .DEAD_CYCLES   (2),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .value (value),
    .dp    (dp),
    .blank (blank),
    .lz_en (lz_en),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'h0000_00FF);
    check({tag, "_an"},  32'(an),  32'h0000_000F);
  endtask

  // One full 8-cycle slot starting at div=0: 2 dark cycles, then 6 with the anode low.
  // Optionally pulses load on the last (wrap) edge.
  task automatic check_slot(input string tag, input int dig, input logic [7:0] exp_seg,
                            input bit load_last);
    logic [3:0] an_exp;
    an_exp = 4'hF & ~(4'b0001 << dig);
    for (int c = 0; c < 8; c++) begin
      if (load_last && c == 7) load = 1'b1;
      tick();
      load = 1'b0;
      check($sformatf("%s_an%0d", tag, c), 32'(an), 32'((c < 2) ? 4'hF : an_exp));
      check($sformatf("%s_seg%0d", tag, c), 32'(seg), 32'(exp_seg));
    end
    $display("slot %s digit %0d seg=%02h an=%04b", tag, dig, seg, an);
  endtask

  // Load new shadow data with the scan stopped, then start scanning at digit 0.
  task automatic restart(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic lz);
    en    = 1'b0;
    value = v;
    dp    = d;
    blank = b;
    lz_en = lz;
    load  = 1'b1;
    tick();
    check_dark("restart");
    load = 1'b0;
    en   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0;
    value = 16'h0; dp = 4'h0; blank = 4'h0; lz_en = 1'b0;

    // Reset held with en=1, then released with en=0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_dark("reset");
    end
    rst_n = 1'b1; en = 1'b0;
    tick(); check_dark("idle0");
    tick(); check_dark("idle1");

    // Basic scan of 0x1234 including wrap back to digit 0.
    restart(16'h1234, 4'h0, 4'h0, 1'b0);
    check_slot("basic_d0", 0, 8'h99, 1'b0);
    check_slot("basic_d1", 1, 8'hB0, 1'b0);
    check_slot("basic_d2", 2, 8'hA4, 1'b0);
    check_slot("basic_d3", 3, 8'hF9, 1'b0);
    check_slot("basic_wrap", 0, 8'h99, 1'b0);

    // Decimal point and blank.
    restart(16'hABCD, 4'b0100, 4'b0001, 1'b0);
    check_slot("blank_d0", 0, 8'hFF, 1'b0);
    check_slot("dpb_d1", 1, 8'hC6, 1'b0);
    check_slot("dp_d2", 2, 8'h03, 1'b0);
    check_slot("dpb_d3", 3, 8'h88, 1'b0);

    // Leading-zero suppression.
    restart(16'h0050, 4'h0, 4'h0, 1'b1);
    check_slot("lz_d0", 0, 8'hC0, 1'b0);
    check_slot("lz_d1", 1, 8'h92, 1'b0);
    check_slot("lz_d2", 2, 8'hFF, 1'b0);
    check_slot("lz_d3", 3, 8'hFF, 1'b0);
    restart(16'h0050, 4'b0100, 4'h0, 1'b1);
    check_slot("lzdp_d0", 0, 8'hC0, 1'b0);
    check_slot("lzdp_d1", 1, 8'h92, 1'b0);
    check_slot("lzdp_d2", 2, 8'h40, 1'b0);
    check_slot("lzdp_d3", 3, 8'hFF, 1'b0);
    restart(16'h0000, 4'h0, 4'h0, 1'b1);
    check_slot("lz0_d0", 0, 8'hC0, 1'b0);
    check_slot("lz0_d1", 1, 8'hFF, 1'b0);
    check_slot("lz0_d2", 2, 8'hFF, 1'b0);
    check_slot("lz0_d3", 3, 8'hFF, 1'b0);

    // Value changes without load are ignored; load on the wrap edge into digit 0.
    restart(16'h1234, 4'h0, 4'h0, 1'b0);
    check_slot("ld_d0", 0, 8'h99, 1'b0);
    check_slot("ld_d1", 1, 8'hB0, 1'b0);
    check_slot("ld_d2", 2, 8'hA4, 1'b0);
    value = 16'h5678;
    check_slot("ld_old_d3", 3, 8'hF9, 1'b1);
    check_slot("ld_new_d0", 0, 8'h80, 1'b0);
    check_slot("ld_new_d1", 1, 8'hF8, 1'b0);

    // Drop en in the middle of digit 2 for 5 cycles.
    for (int i = 0; i < 4; i++) tick();
    check("en_mid_an", 32'(an), 32'h0000_000B);
    check("en_mid_seg", 32'(seg), 32'h0000_0082);
    en = 1'b0;
    tick(); check_dark("en_off_first");
    for (int i = 0; i < 4; i++) tick();
    check_dark("en_off_last");
    en = 1'b1;
    check_slot("en_resume_d0", 0, 8'h80, 1'b0);

    // Reset in the middle of digit 1 clears shadow data too.
    for (int i = 0; i < 4; i++) tick();
    check("rst_mid_an", 32'(an), 32'h0000_000D);
    check("rst_mid_seg", 32'(seg), 32'h0000_00F8);
    rst_n = 1'b0;
    tick(); check_dark("rst_mid");
    rst_n = 1'b1;
    check_slot("rst_resume_d0", 0, 8'hC0, 1'b0);
    check_slot("rst_resume_d1", 1, 8'hC0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
